// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: load length, write-data select, WB control word.
package mem_wb_stage_pkg;

   typedef enum logic [2:0] {
      ML_WORD   = 3'b000,
      ML_HALF_S = 3'b001,
      ML_HALF_U = 3'b010,
      ML_BYTE_S = 3'b011,
      ML_BYTE_U = 3'b100
   } memlen_e;

   typedef enum logic [1:0] {
      WD_ALU  = 2'b00,
      WD_MEM  = 2'b01,
      WD_LINK = 2'b10,
      WD_ZERO = 2'b11
   } cregwd_e;

   typedef struct packed {
      logic       valid;
      logic       regwe;
      logic [1:0] cregwd;
      logic [2:0] memlen;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_extend.sv
// Little-endian load-data lane select and sign/zero extension of an aligned memory word.
module load_extend
   import mem_wb_stage_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] word,
   input  logic [1:0]    addr,
   input  logic [2:0]    memlen,
   output logic [DW-1:0] ext
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[7:0];
      case (addr)
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      // halves ignore addr[0]; misalignment is not trapped here
      h = addr[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      ext = word;
      case (memlen)
         ML_HALF_S: ext = {{(DW-16){h[15]}}, h};
         ML_HALF_U: ext = {{(DW-16){1'b0}}, h};
         ML_BYTE_S: ext = {{(DW-8){b[7]}}, b};
         ML_BYTE_U: ext = {{(DW-8){1'b0}}, b};
         default:   ext = word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback data select, register-file write port and retire counter.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic            regwe_i,
   input  logic [1:0]      cregwd_i,
   input  logic [AW-1:0]   wa_i,
   input  logic [DW-1:0]   aluout_i,
   input  logic [DW-1:0]   memrd_i,
   input  logic [2:0]      memlen_i,
   input  logic [DW-1:0]   pc8_i,
   output logic            we_wb,
   output logic [AW-1:0]   wa_wb,
   output logic [DW-1:0]   wd_wb,
   output logic            valid_o,
   output logic [CNTW-1:0] instret_o
);

   wb_ctrl_t        ctrl_q;
   logic [AW-1:0]   wa_q;
   logic [DW-1:0]   alu_q, mem_q, pc8_q, ld_data;
   logic [CNTW-1:0] instret_q;
   logic            capture;

   assign capture = valid_i & ~stall_i & ~flush_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q <= WB_CTRL_BUBBLE;
         wa_q   <= '0;
         alu_q  <= '0;
         mem_q  <= '0;
         pc8_q  <= '0;
      end else if (flush_i) begin
         ctrl_q <= WB_CTRL_BUBBLE;
         wa_q   <= '0;
         alu_q  <= '0;
         mem_q  <= '0;
         pc8_q  <= '0;
      end else if (!stall_i) begin
         ctrl_q <= '{valid: valid_i, regwe: regwe_i, cregwd: cregwd_i, memlen: memlen_i};
         wa_q   <= wa_i;
         alu_q  <= aluout_i;
         mem_q  <= memrd_i;
         pc8_q  <= pc8_i;
      end
   end

   // free-running, wraps silently
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         instret_q <= '0;
      else if (capture) instret_q <= instret_q + 1'b1;
   end

   load_extend #(.DW(DW)) u_load_extend (
      .word   (mem_q),
      .addr   (alu_q[1:0]),
      .memlen (ctrl_q.memlen),
      .ext    (ld_data)
   );

   always_comb begin
      wd_wb = '0;
      case (ctrl_q.cregwd)
         WD_ALU:  wd_wb = alu_q;
         WD_MEM:  wd_wb = ld_data;
         WD_LINK: wd_wb = pc8_q;
         default: wd_wb = '0;
      endcase
   end

   // $0 is hardwired; a stalled instruction keeps rewriting the same value
   assign we_wb     = ctrl_q.valid & ctrl_q.regwe & (wa_q != '0);
   assign wa_wb     = wa_q;
   assign valid_o   = ctrl_q.valid;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: random + directed traffic against a behavioural model.
module tb_mem_wb_stage;

   localparam int CNTW = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 0, flush_i = 0, valid_i = 0, regwe_i = 0;
   logic [1:0]  cregwd_i = 0;
   logic [4:0]  wa_i = 0;
   logic [31:0] aluout_i = 0, memrd_i = 0, pc8_i = 0;
   logic [2:0]  memlen_i = 0;
   logic        we_wb, valid_o;
   logic [4:0]  wa_wb;
   logic [31:0] wd_wb;
   logic [CNTW-1:0] instret_o;

   mem_wb_stage #(.DW(32), .AW(5), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .regwe_i(regwe_i), .cregwd_i(cregwd_i), .wa_i(wa_i), .aluout_i(aluout_i),
      .memrd_i(memrd_i), .memlen_i(memlen_i), .pc8_i(pc8_i), .we_wb(we_wb),
      .wa_wb(wa_wb), .wd_wb(wd_wb), .valid_o(valid_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        v;
      int          cnt;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // model of the instruction currently sitting in WB
   logic        m_v, m_rw;
   logic [1:0]  m_cw;
   logic [4:0]  m_wa;
   logic [31:0] m_alu, m_mem, m_pc8;
   logic [2:0]  m_len;
   int          m_cnt;

   function automatic logic [31:0] load_val(input logic [31:0] mem, input logic [31:0] addr,
                                            input logic [2:0] len);
      int unsigned lane, v;
      lane = addr % 4;
      case (len)
         3'd1, 3'd2: begin
            v = (mem >> ((lane / 2) * 16)) % 65536;
            if (len == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
         end
         3'd3, 3'd4: begin
            v = (mem >> (lane * 8)) % 256;
            if (len == 3'd3 && v >= 128) v = v + 32'hFFFFFF00;
         end
         default: v = mem;
      endcase
      return v;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.v   = m_v;
      e.wa  = m_wa;
      e.we  = m_v && m_rw && (m_wa != 0);
      e.cnt = m_cnt;
      case (m_cw)
         2'd0: e.wd = m_alu;
         2'd1: e.wd = load_val(m_mem, m_alu, m_len);
         2'd2: e.wd = m_pc8;
         default: e.wd = 0;
      endcase
      return e;
   endfunction

   task automatic model_clear();
      m_v = 0; m_rw = 0; m_cw = 0; m_wa = 0; m_alu = 0; m_mem = 0; m_pc8 = 0; m_len = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // one MEM-stage slot: drive after negedge, update model after posedge, queue the result
   task automatic step(input logic v, input logic rw, input logic st, input logic fl,
                       input logic [1:0] cw, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [2:0] len, input logic [31:0] pc8);
      @(negedge clk);
      valid_i = v; regwe_i = rw; stall_i = st; flush_i = fl; cregwd_i = cw; wa_i = wa;
      aluout_i = alu; memrd_i = mem; memlen_i = len; pc8_i = pc8;
      @(posedge clk);
      #1;
      if (fl) model_clear();
      else if (!st) begin
         m_v = v; m_rw = rw; m_cw = cw; m_wa = wa; m_alu = alu; m_mem = mem; m_len = len;
         m_pc8 = pc8;
         if (v) m_cnt = (m_cnt + 1) % (1 << CNTW);
      end
      q.push_back(model_out());
   endtask

   task automatic ld(input logic [31:0] mem, input logic [31:0] alu, input logic [2:0] len,
                     input logic [31:0] exp, input string name);
      step(1, 1, 0, 0, 2'd1, 5'd7, alu, mem, len, 0);
      chk(name, wd_wb, exp);
   endtask

   task automatic rand_step();
      logic st, fl;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), st, fl, 2'($urandom),
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
           3'($urandom), $urandom);
   endtask

   // monitor: compare every presented WB output against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (we_wb !== e.we || wa_wb !== e.wa || wd_wb !== e.wd || valid_o !== e.v ||
                instret_o !== CNTW'(e.cnt)) begin
               miscompares++;
               $display("FAIL wb_out: got we=%0b wa=%0d wd=0x%08h v=%0b cnt=%0d expected we=%0b wa=%0d wd=0x%08h v=%0b cnt=%0d",
                        we_wb, wa_wb, wd_wb, valid_o, instret_o, e.we, e.wa, e.wd, e.v, e.cnt);
            end
         end
      end
   end

   initial begin
      model_clear();
      m_cnt = 0;
      #3;
      chk("reset_outputs", {we_wb, wa_wb, valid_o, 25'd0}, 32'd0);
      chk("reset_wd", wd_wb, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // byte loads, each lane, then zero-extended top lane
      ld(32'h80FF7F01, 32'h100, 3'd3, 32'h00000001, "byte_s_lane0");
      ld(32'h80FF7F01, 32'h101, 3'd3, 32'h0000007F, "byte_s_lane1");
      ld(32'h80FF7F01, 32'h102, 3'd3, 32'hFFFFFFFF, "byte_s_lane2");
      ld(32'h80FF7F01, 32'h103, 3'd3, 32'hFFFFFF80, "byte_s_lane3");
      ld(32'h80FF7F01, 32'h103, 3'd4, 32'h00000080, "byte_u_lane3");
      // half loads, addr[0] ignored; reserved length behaves as word
      ld(32'h8000FFFE, 32'h202, 3'd1, 32'hFFFF8000, "half_s_hi");
      ld(32'h8000FFFE, 32'h200, 3'd2, 32'h0000FFFE, "half_u_lo");
      ld(32'h8000FFFE, 32'h201, 3'd2, 32'h0000FFFE, "half_u_odd");
      ld(32'h8000FFFE, 32'h203, 3'd6, 32'h8000FFFE, "len_rsvd_word");

      // stall holds a captured instruction, counted once
      step(1, 1, 0, 0, 2'd0, 5'd5, 32'h1234, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 2'd2, 5'd9, $urandom, $urandom, 0, $urandom);
      chk("stall_wd", wd_wb, 32'h1234);
      chk("stall_we_wa", {26'd0, we_wb, wa_wb}, {26'd0, 1'b1, 5'd5});
      step(1, 1, 1, 1, 2'd0, 5'd6, 32'h55, 0, 0, 0);
      chk("flush_stall", {30'd0, valid_o, we_wb}, 32'd0);

      // $0 guard and link write
      step(1, 1, 0, 0, 2'd0, 5'd0, 32'hDEAD, 0, 0, 0);
      chk("zero_guard_we", {31'd0, we_wb}, 32'd0);
      step(1, 1, 0, 0, 2'd2, 5'd31, 32'hDEAD, 0, 0, 32'h400008);
      chk("link_wd", wd_wb, 32'h00400008);
      chk("link_we", {31'd0, we_wb}, 32'd1);

      for (int i = 0; i < 150; i++) rand_step();

      // async reset in the middle of a stall
      @(negedge clk);
      stall_i = 1; flush_i = 1;
      #2 rst = 1'b0;
      #1;
      chk("midrun_reset_out", {26'd0, we_wb, valid_o, 4'd0} | {27'd0, wa_wb}, 32'd0);
      chk("midrun_reset_cnt", 32'(instret_o), 32'd0);
      model_clear();
      m_cnt = 0;
      q.delete();
      #2 rst = 1'b1;

      // drive the counter to its top value, then one more capture must wrap
      while (m_cnt != (1 << CNTW) - 1) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 2'd0, 5'd3, 32'h77, 0, 0, 0);
      chk("counter_wrap", 32'(instret_o), 32'd0);

      for (int i = 0; i < 150; i++) rand_step();

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
